fp_image_loader: RTL and testbench

//  Synthesizable sequencer that deposits a memory image into the PDP-8 through the Front_Panel

---
 rtl/fp_image_loader.sv | 173 +++++++++++++++++
 tb/tb_fp_image_loader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_image_loader.sv
// rtl/fp_image_loader.sv - deposits an (address,data) word stream into the PDP-8 through the front-panel switches and buttons

module fp_image_loader #(
    parameter int          SETUP_CYC   = 10,
    parameter int          PULSE_CYC   = 10,
    parameter int          GAP_CYC     = 10,
    parameter logic [11:0] START_PC    = 12'o0200,
    parameter bit          SKIP_CONSEC = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_valid,
    input  logic [11:0] word_addr,
    input  logic [11:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic [12:0] sw,
    output logic        btnl,
    output logic        btnd,
    output logic        busy,
    output logic        done,
    output logic [12:0] words_loaded
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [3:0] {
        IDLE,
        A_SETUP, A_PULSE, A_GAP,
        D_SETUP, D_PULSE, D_GAP,
        P_SETUP, P_PULSE, P_GAP,
        RUN
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [11:0]   addr_q, addr_n;
    logic [11:0]   data_q, data_n;
    logic          last_q, last_n;
    logic [11:0]   prev_addr, prev_addr_n;
    logic          prev_valid, prev_valid_n;
    logic [12:0]   sw_q, sw_n;
    logic          btnl_q, btnl_n;
    logic          btnd_q, btnd_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          ready_q, ready_n;
    logic [12:0]   wl_q, wl_n;
    logic [11:0]   prev_next;
    logic          accept;
    logic          expired;

    // Counter holds (dwell - 1) on entry, so a state lasts exactly its dwell in cycles.
    function automatic logic [CW-1:0] dwell(input state_t s);
        case (s)
            A_SETUP, D_SETUP, P_SETUP: dwell = CW'(SETUP_CYC - 1);
            A_PULSE, D_PULSE, P_PULSE: dwell = CW'(PULSE_CYC - 1);
            A_GAP,   D_GAP,   P_GAP:   dwell = CW'(GAP_CYC - 1);
            default:                   dwell = '0;
        endcase
    endfunction

    assign prev_next = prev_addr + 12'd1;
    assign accept    = ready_q & word_valid;
    assign expired   = (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            prev_addr  <= '0;
            prev_valid <= 1'b0;
            sw_q       <= '0;
            btnl_q     <= 1'b0;
            btnd_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            wl_q       <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            addr_q     <= addr_n;
            data_q     <= data_n;
            last_q     <= last_n;
            prev_addr  <= prev_addr_n;
            prev_valid <= prev_valid_n;
            sw_q       <= sw_n;
            btnl_q     <= btnl_n;
            btnd_q     <= btnd_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            ready_q    <= ready_n;
            wl_q       <= wl_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        addr_n       = addr_q;
        data_n       = data_q;
        last_n       = last_q;
        prev_addr_n  = prev_addr;
        prev_valid_n = prev_valid;
        wl_n         = wl_q;

        case (state)
            IDLE: begin
                if (accept) begin
                    addr_n  = word_addr;
                    data_n  = word_data;
                    last_n  = word_last;
                    state_n = (SKIP_CONSEC && prev_valid && (word_addr == prev_next))
                              ? D_SETUP : A_SETUP;
                end
            end
            A_SETUP: if (expired) state_n = A_PULSE;
            A_PULSE: if (expired) state_n = A_GAP;
            A_GAP:   if (expired) state_n = D_SETUP;
            D_SETUP: if (expired) state_n = D_PULSE;
            D_PULSE: if (expired) state_n = D_GAP;
            D_GAP: begin
                if (expired) begin
                    wl_n         = (wl_q == 13'd4096) ? wl_q : wl_q + 13'd1;
                    prev_addr_n  = addr_q;
                    prev_valid_n = 1'b1;
                    state_n      = last_q ? P_SETUP : IDLE;
                end
            end
            P_SETUP: if (expired) state_n = P_PULSE;
            P_PULSE: if (expired) state_n = P_GAP;
            P_GAP:   if (expired) state_n = RUN;
            RUN:     state_n = RUN;
            default: state_n = IDLE;
        endcase

        if (state_n != state) begin
            cnt_n = dwell(state_n);
        end else if (!expired) begin
            cnt_n = cnt - CW'(1);
        end

        // Outputs are decoded from the next state so every port comes straight off a flop.
        sw_n = {1'b0, sw_q[11:0]};
        case (state_n)
            A_SETUP: sw_n[11:0] = addr_n;
            D_SETUP: sw_n[11:0] = data_n;
            P_SETUP: sw_n[11:0] = START_PC;
            default: sw_n[11:0] = sw_q[11:0];
        endcase
        sw_n[12] = (state_n == RUN);
        btnl_n   = (state_n == A_PULSE) || (state_n == P_PULSE);
        btnd_n   = (state_n == D_PULSE);
        busy_n   = (state_n != IDLE) && (state_n != RUN);
        done_n   = (state_n == RUN);
        ready_n  = (state_n == IDLE);
    end

    assign word_ready   = ready_q;
    assign sw           = sw_q;
    assign btnl         = btnl_q;
    assign btnd         = btnd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_fp_image_loader.sv
// tb/tb_fp_image_loader.sv - schedule-model checker for fp_image_loader with directed image words

module tb_fp_image_loader;

    localparam int          S     = 10;
    localparam int          P     = 10;
    localparam int          G     = 10;
    localparam logic [11:0] SPC   = 12'o0200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        word_valid = 1'b0;
    logic [11:0] word_addr = '0;
    logic [11:0] word_data = '0;
    logic        word_last = 1'b0;
    logic        word_ready;
    logic [12:0] sw;
    logic        btnl;
    logic        btnd;
    logic        busy;
    logic        done;
    logic [12:0] words_loaded;

    fp_image_loader #(
        .SETUP_CYC(S), .PULSE_CYC(P), .GAP_CYC(G), .START_PC(SPC), .SKIP_CONSEC(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .word_valid(word_valid), .word_addr(word_addr), .word_data(word_data),
        .word_last(word_last), .word_ready(word_ready),
        .sw(sw), .btnl(btnl), .btnd(btnd), .busy(busy), .done(done),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    // Model: each accepted word expands into a list of per-cycle expected panel states.
    typedef struct {
        logic [11:0] v;
        logic        l;
        logic        d;
        logic        fin;
        logic        run;
    } rec_t;

    rec_t        q[$];
    logic [12:0] e_sw = '0;
    logic        e_btnl = 0, e_btnd = 0, e_busy = 0, e_done = 0, e_ready = 0;
    logic [12:0] e_wl = '0;
    int          m_wl = 0;
    logic        m_done = 0, m_prev_v = 0, cur_fin = 0, cur_run = 0;
    logic [11:0] m_prev = '0;

    task automatic push_seg(input int n, input logic [11:0] v, input logic l, input logic d,
                            input logic fin, input logic run);
        for (int i = 0; i < n; i++)
            q.push_back('{v, l, d, fin && (i == n - 1), run && (i == n - 1)});
    endtask

    task automatic push_word(input logic [11:0] a, input logic [11:0] d, input logic last);
        logic [11:0] nxt;
        nxt = m_prev + 12'd1;
        if (!(m_prev_v && a == nxt)) begin
            push_seg(S, a, 0, 0, 0, 0);
            push_seg(P, a, 1, 0, 0, 0);
            push_seg(G, a, 0, 0, 0, 0);
        end
        push_seg(S, d, 0, 0, 0, 0);
        push_seg(P, d, 0, 1, 0, 0);
        push_seg(G, d, 0, 0, 1, 0);
        if (last) begin
            push_seg(S, SPC, 0, 0, 0, 0);
            push_seg(P, SPC, 1, 0, 0, 0);
            push_seg(G, SPC, 0, 0, 0, 1);
        end
        m_prev   = a;
        m_prev_v = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            e_sw = '0; e_btnl = 0; e_btnd = 0; e_busy = 0; e_done = 0; e_ready = 0; e_wl = '0;
            m_wl = 0; m_done = 0; m_prev_v = 0; cur_fin = 0; cur_run = 0;
        end else begin
            if (cur_fin) m_wl = (m_wl < 4096) ? m_wl + 1 : 4096;
            if (cur_run) m_done = 1'b1;
            cur_fin = 0;
            cur_run = 0;
            if (word_valid && e_ready) push_word(word_addr, word_data, word_last);
            if (q.size() > 0) begin
                rec_t r;
                r = q.pop_front();
                e_sw = {1'b0, r.v}; e_btnl = r.l; e_btnd = r.d;
                cur_fin = r.fin; cur_run = r.run;
                e_busy = 1; e_done = 0; e_ready = 0;
            end else begin
                e_sw[12] = m_done; e_btnl = 0; e_btnd = 0;
                e_busy = 0; e_done = m_done; e_ready = !m_done;
            end
            e_wl = 13'(m_wl);
        end
    end

    logic        checking = 0;
    logic        p_btnl = 0, p_btnd = 0;
    logic [11:0] p_sw = '0;
    int          btnl_hi = 0, btnd_hi = 0, btnl_rises = 0;
    logic [11:0] last_l_sw = '0, last_d_sw = '0;

    always @(negedge clk) begin
        if (checking) begin
            chk("sw", 32'(sw), 32'(e_sw));
            chk("btnl", 32'(btnl), 32'(e_btnl));
            chk("btnd", 32'(btnd), 32'(e_btnd));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("word_ready", 32'(word_ready), 32'(e_ready));
            chk("words_loaded", 32'(words_loaded), 32'(e_wl));
            chk("btn_overlap", 32'(btnl & btnd), 32'd0);
            if ((btnl || btnd) && (p_btnl || p_btnd))
                chk("sw_stable_btn", 32'(sw[11:0]), 32'(p_sw));
            if (btnl) btnl_hi++;
            if (btnd) btnd_hi++;
            if (btnl && !p_btnl) begin btnl_rises++; last_l_sw = sw[11:0]; end
            if (btnd && !p_btnd) last_d_sw = sw[11:0];
            p_btnl = btnl;
            p_btnd = btnd;
            p_sw   = sw[11:0];
        end
    end

    task automatic send_word(input logic [11:0] a, input logic [11:0] d, input logic l,
                             input bit measure, output int lat);
        bit acc;
        acc = 0;
        word_addr = a; word_data = d; word_last = l; word_valid = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            if (e_ready) acc = 1;
            @(posedge clk); #1;
        end
        word_valid = 1'b0;
        word_addr  = 12'($urandom);
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        lat = 0;
        if (measure) begin
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                lat++;
                if (word_ready === 1'b1) break;
                // Traffic offered while not ready must be ignored.
                word_valid = e_ready ? 1'b0 : 1'($urandom_range(0, 1));
                word_addr  = 12'($urandom);
                word_data  = 12'($urandom);
                word_last  = 1'($urandom);
            end
            word_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    int lat, b_hi_l, b_hi_d, b_rise;

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        // Reset
        @(posedge clk); #1 checking = 1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(word_ready), 32'd0);
        chk("rst_sw", 32'(sw), 32'd0);
        chk("rst_wl", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(word_ready), 32'd1);

        // Single last word
        b_hi_l = btnl_hi; b_hi_d = btnd_hi;
        send_word(12'o0200, 12'o7402, 1'b1, 0, lat);
        for (int i = 0; i < 200 && !e_done; i++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk); #1;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_sw_run", 32'(sw), 32'(13'o10200));
        chk("t2_wl", 32'(words_loaded), 32'd1);
        chk("t2_btnl_cycles", 32'(btnl_hi - b_hi_l), 32'd20);
        chk("t2_btnd_cycles", 32'(btnd_hi - b_hi_d), 32'd10);
        chk("t2_btnl_sw", 32'(last_l_sw), 32'(12'o0200));
        chk("t2_btnd_sw", 32'(last_d_sw), 32'(12'o7402));
        chk("t2_ready_in_run", 32'(word_ready), 32'd0);

        // Consecutive addresses
        reset_dut();
        b_rise = btnl_rises;
        send_word(12'o0200, 12'o1000, 1'b0, 1, lat);
        chk("t3_lat_full", 32'(lat), 32'd61);
        send_word(12'o0201, 12'o2000, 1'b0, 1, lat);
        chk("t3_lat_skip", 32'(lat), 32'd31);
        chk("t3_btnl_pulses", 32'(btnl_rises - b_rise), 32'd1);
        chk("t3_wl", 32'(words_loaded), 32'd2);
        chk("t3_btnd_sw", 32'(last_d_sw), 32'(12'o2000));

        // Non-consecutive addresses
        reset_dut();
        b_rise = btnl_rises;
        send_word(12'o0200, 12'o0000, 1'b0, 1, lat);
        send_word(12'o0300, 12'o0000, 1'b0, 1, lat);
        chk("t4_lat", 32'(lat), 32'd61);
        chk("t4_btnl_pulses", 32'(btnl_rises - b_rise), 32'd2);
        chk("t4_btnl_sw", 32'(last_l_sw), 32'(12'o0300));
        chk("t4_wl", 32'(words_loaded), 32'd2);

        // Address wrap
        reset_dut();
        b_rise = btnl_rises;
        send_word(12'o7777, 12'o0001, 1'b0, 1, lat);
        send_word(12'o0000, 12'o0002, 1'b0, 1, lat);
        chk("t5_lat_wrap", 32'(lat), 32'd31);
        chk("t5_btnl_pulses", 32'(btnl_rises - b_rise), 32'd1);

        // Reset during a deposit pulse
        reset_dut();
        send_word(12'o0177, 12'o1111, 1'b0, 1, lat);
        send_word(12'o0200, 12'o2222, 1'b0, 0, lat);
        for (int i = 0; i < 60 && !e_btnd; i++) begin @(posedge clk); #1; end
        repeat (4) @(posedge clk); #1;
        chk("t6_btnd_before", 32'(btnd), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_btnd_async", 32'(btnd), 32'd0);
        chk("t6_wl_rst", 32'(words_loaded), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_ready", 32'(word_ready), 32'd1);
        b_rise = btnl_rises;
        send_word(12'o0200, 12'o3333, 1'b0, 1, lat);
        chk("t6_lat_full", 32'(lat), 32'd61);
        chk("t6_btnl_pulses", 32'(btnl_rises - b_rise), 32'd1);
        chk("t6_wl", 32'(words_loaded), 32'd1);

        repeat (2) @(posedge clk);
        #1 checking = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
